e_mdu: RTL and testbench

// - E-stage multiply/divide unit. Executes mult/multu/div/divu/mthi/mtlo with multi-cycle latency.
// - Owns the architectural HI/LO registers. HI/LO travel down the pipeline as E_HI/E_LO -> M_HI/M_LO for mfhi/mflo writeback.
// - Drives a stall request to the hazard unit while an operation is pending.

---
 rtl/e_mdu_pkg.sv | 47 ++++
 rtl/e_mdu_arith.sv | 80 ++++++++
 rtl/e_mdu.sv | 94 +++++++++
 tb/tb_e_mdu.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/e_mdu_pkg.sv
// ============================================================================
// Package : e_mdu_pkg
// Purpose : Operation codes, default latencies and decode helpers shared by
//           the E-stage multiply/divide unit and its arithmetic datapath.
// Config  : MDU_MADD_EN enables the MADD/MADDU accumulate operations.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Multiply-class ops take MULT_CYCLES; MADD/MADDU only exist when enabled.
  function automatic logic is_mult_class(input logic [3:0] op);
    logic r;
    r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_MADD) || (op == MDU_MADDU);
`endif
    return r;
  endfunction

  function automatic logic is_div_class(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage : e_mdu_pkg

`default_nettype wire

// File: rtl/e_mdu_arith.sv
// ============================================================================
// Module  : e_mdu_arith
// Purpose : Purely combinational arithmetic for the MDU. Produces the
//           {HI,LO} result for the op presented and flags divide-by-zero.
// Config  : MDU_MADD_EN adds the {HI,LO} accumulate adder for MADD/MADDU.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module e_mdu_arith
  import e_mdu_pkg::*;
(
  input  logic [3:0]  MDUOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic [31:0] HI,
  input  logic [31:0] LO,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic [63:0] smul;
  logic [63:0] umul;
  logic        is_sdiv;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] den_safe;
  logic [31:0] quo;
  logic [31:0] rem;

  // Signed product via explicit sign extension; unsigned via zero extension.
  assign smul = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
  assign umul = {32'b0, E_A} * {32'b0, E_B};

  // One unsigned divider serves both DIV and DIVU: signed division works on
  // magnitudes and fixes signs afterwards, which also yields 0x80000000/-1 =
  // 0x80000000 rem 0 without any special case.
  assign is_sdiv  = (MDUOp == MDU_DIV);
  assign num      = (is_sdiv && E_A[31]) ? (32'd0 - E_A) : E_A;
  assign den      = (is_sdiv && E_B[31]) ? (32'd0 - E_B) : E_B;
  assign den_safe = (den == 32'd0) ? 32'd1 : den;
  assign quo      = num / den_safe;
  assign rem      = num % den_safe;

  // Select the result for the current op.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    div0   = 1'b0;
    case (MDUOp)
      MDU_MULT:  {res_hi, res_lo} = smul;
      MDU_MULTU: {res_hi, res_lo} = umul;
      MDU_DIV: begin
        res_lo = (E_A[31] ^ E_B[31]) ? (32'd0 - quo) : quo;
        res_hi = E_A[31] ? (32'd0 - rem) : rem;
        div0   = (E_B == 32'd0);
      end
      MDU_DIVU: begin
        res_lo = quo;
        res_hi = rem;
        div0   = (E_B == 32'd0);
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  {res_hi, res_lo} = {HI, LO} + smul;
      MDU_MADDU: {res_hi, res_lo} = {HI, LO} + umul;
`endif
      default: ;
    endcase
  end

`ifndef MDU_MADD_EN
  // HI/LO only feed the accumulate path, which is absent in this build.
  logic unused_hilo;
  assign unused_hilo = ^{HI, LO};
`endif

endmodule : e_mdu_arith

`default_nettype wire

// File: rtl/e_mdu.sv
// ============================================================================
// Module  : e_mdu
// Purpose : E-stage multiply/divide unit. Holds HI/LO, a shadow result and a
//           down-counter that models multi-cycle latency; raises MDU_Stall
//           while an operation is being issued or is in flight.
// Config  : MDU_MADD_EN enables MADD/MADDU (accumulate into HI/LO).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        busy,
  output logic        MDU_Stall,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [31:0]      sh_hi;
  logic [31:0]      sh_lo;
  logic             commit_en;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             div0;
  logic             op_mult;
  logic             op_div;

  e_mdu_arith u_arith (
    .MDUOp  (MDUOp),
    .E_A    (E_A),
    .E_B    (E_B),
    .HI     (hi),
    .LO     (lo),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .div0   (div0)
  );

  assign op_mult   = is_mult_class(MDUOp);
  assign op_div    = is_div_class(MDUOp);
  assign busy      = (cnt != '0);
  assign MDU_Stall = (start & (op_mult | op_div)) | busy;
  assign E_HI      = hi;
  assign E_LO      = lo;

  // Issue ops when idle; otherwise count down and commit the shadow once.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      sh_hi     <= 32'd0;
      sh_lo     <= 32'd0;
      commit_en <= 1'b0;
    end else if (!busy) begin
      if (start) begin
        if (op_mult || op_div) begin
          sh_hi     <= res_hi;
          sh_lo     <= res_lo;
          commit_en <= ~div0;
          cnt       <= op_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (MDUOp == MDU_MTHI) begin
          hi <= E_A;
        end else if (MDUOp == MDU_MTLO) begin
          lo <= E_A;
        end
      end
    end else begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1) && commit_en) begin
        hi <= sh_hi;
        lo <= sh_lo;
      end
    end
  end

endmodule : e_mdu

`default_nettype wire

// File: tb/tb_e_mdu.sv
// ============================================================================
// Module  : tb_e_mdu
// Purpose : Self-checking bench for e_mdu: directed cases plus random ops
//           compared against an arithmetic reference model of HI/LO.
// Config  : MDU_MADD_EN selects the expected MADD/MADDU behaviour.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  MDUOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        busy;
  logic        MDU_Stall;
  logic [31:0] E_HI;
  logic [31:0] E_LO;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi     = 32'd0;
  logic [31:0] m_lo     = 32'd0;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .MDUOp     (MDUOp),
    .E_A       (E_A),
    .E_B       (E_B),
    .busy      (busy),
    .MDU_Stall (MDU_Stall),
    .E_HI      (E_HI),
    .E_LO      (E_LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge and follow it to completion, checking the
  // stall strobe, busy duration, HI/LO hold during busy and the final values.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nh, nl;
    logic [63:0] p;
    longint      q, r;
    int          lat;
    nh  = m_hi;
    nl  = m_lo;
    lat = 0;
    case (op)
      4'd1: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); nh = p[63:32]; nl = p[31:0]; lat = MC; end
      4'd2: begin p = {32'b0, a} * {32'b0, b}; nh = p[63:32]; nl = p[31:0]; lat = MC; end
      4'd3: begin
        lat = DC;
        if (b != 0) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          nl = q[31:0]; nh = r[31:0];
        end
      end
      4'd4: begin
        lat = DC;
        if (b != 0) begin nl = a / b; nh = a % b; end
      end
      4'd5: nh = a;
      4'd6: nl = a;
`ifdef MDU_MADD_EN
      4'd7: begin p = {m_hi, m_lo} + 64'(longint'($signed(a)) * longint'($signed(b))); nh = p[63:32]; nl = p[31:0]; lat = MC; end
      4'd8: begin p = {m_hi, m_lo} + {32'b0, a} * {32'b0, b}; nh = p[63:32]; nl = p[31:0]; lat = MC; end
`endif
      default: ;
    endcase
    start = 1'b1; MDUOp = op; E_A = a; E_B = b;
    #1;
    check("stall_at_start", 32'(MDU_Stall), 32'(lat != 0));
    @(negedge clk);
    start = 1'b0; MDUOp = 4'd0;
    for (int i = 0; i < lat; i++) begin
      check("busy_high", 32'(busy), 32'd1);
      check("stall_busy", 32'(MDU_Stall), 32'd1);
      check("hi_hold", E_HI, m_hi);
      check("lo_hold", E_LO, m_lo);
      @(negedge clk);
    end
    check("busy_done", 32'(busy), 32'd0);
    check("hi_result", E_HI, nh);
    check("lo_result", E_LO, nl);
    m_hi = nh;
    m_lo = nl;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; MDUOp = 4'd0; E_A = 32'd0; E_B = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_stall", 32'(MDU_Stall), 32'd0);
    check("reset_hi", E_HI, 32'd0);
    check("reset_lo", E_LO, 32'd0);

    // Directed cases
    do_op(4'd1, 32'hFFFFFFFE, 32'd3);
    check("mult_hi_const", E_HI, 32'hFFFFFFFF);
    check("mult_lo_const", E_LO, 32'hFFFFFFFA);
    do_op(4'd2, 32'hFFFFFFFF, 32'd2);
    check("multu_hi_const", E_HI, 32'h00000001);
    check("multu_lo_const", E_LO, 32'hFFFFFFFE);
    do_op(4'd3, 32'hFFFFFFF9, 32'd2);
    check("div_lo_const", E_LO, 32'hFFFFFFFD);
    check("div_hi_const", E_HI, 32'hFFFFFFFF);
    do_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_lo", E_LO, 32'h80000000);
    check("div_ovf_hi", E_HI, 32'h00000000);
    do_op(4'd5, 32'h11, 32'd0);
    do_op(4'd6, 32'h22, 32'd0);
    do_op(4'd4, 32'd9, 32'd0);
    check("div0_hi_const", E_HI, 32'h11);
    check("div0_lo_const", E_LO, 32'h22);
    do_op(4'd0, 32'h1234, 32'h5678);
    do_op(4'd15, 32'h1234, 32'h5678);

    // MADD: HI:LO = 0:10 then 3*4 accumulated (or ignored when disabled)
    do_op(4'd5, 32'd0, 32'd0);
    do_op(4'd6, 32'd10, 32'd0);
    do_op(4'd7, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
    check("madd_lo_const", E_LO, 32'd22);
`else
    check("madd_lo_const", E_LO, 32'd10);
`endif
    check("madd_hi_const", E_HI, 32'd0);

    // Random ops against the reference model
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      if (op > 4'd8 && $urandom_range(0, 3) != 0) op = 4'($urandom_range(1, 6));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'hFFFFFFFF;
      do_op(op, a, b);
    end

    // Reset in the third busy cycle of a multiply aborts it
    start = 1'b1; MDUOp = 4'd1; E_A = 32'd5; E_B = 32'd5;
    @(negedge clk);
    start = 1'b0; MDUOp = 4'd0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", E_HI, 32'd0);
    check("abort_lo", E_LO, 32'd0);
    for (int i = 0; i < MC + 2; i++) begin
      @(negedge clk);
      check("no_late_commit_hi", E_HI, 32'd0);
      check("no_late_commit_lo", E_LO, 32'd0);
      check("no_late_busy", 32'(busy), 32'd0);
    end
    do_op(4'd1, 32'd5, 32'd5);
    check("post_abort_lo", E_LO, 32'd25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_e_mdu

`default_nettype wire
